// File: rtl/cache_refill_ctrl_pkg.sv
// Shared definitions for the cache refill controller: line geometry and FSM encoding.
package cache_refill_ctrl_pkg;

  localparam int BLOCK_BYTES = 32;
  localparam int OFF_W       = 5;
  localparam int LINE_W      = 256;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_WB    = 3'd1,
    ST_FETCH = 3'd2,
    ST_FILL  = 3'd3,
    ST_DONE  = 3'd4
  } state_t;

  // Clear the byte-offset bits so the address points at the start of its line.
  function automatic logic [31:0] line_base(input logic [31:0] addr);
    return addr & ~32'(BLOCK_BYTES - 1);
  endfunction

endpackage

// File: rtl/cache_refill_ctrl_byte_buffer.sv
// 32-byte line buffer: bulk load of a whole line, single-byte indexed write,
// combinational single-byte read and full-line view.
module refill_byte_buffer
  import cache_refill_ctrl_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              i_load,
  input  logic [LINE_W-1:0] i_load_data,
  input  logic              i_wr_en,
  input  logic [OFF_W-1:0]  i_wr_idx,
  input  logic [7:0]        i_wr_byte,
  input  logic [OFF_W-1:0]  i_rd_idx,
  output logic [7:0]        o_rd_byte,
  output logic [LINE_W-1:0] o_block
);

  generate
    for (genvar gi = 0; gi < BLOCK_BYTES; gi++) begin : g_byte
      logic [7:0] r_byte;

      // Each byte takes a whole-line load first, otherwise its own indexed write.
      always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
          r_byte <= '0;
        end else if (i_load) begin
          r_byte <= i_load_data[8*gi +: 8];
        end else if (i_wr_en && (i_wr_idx == OFF_W'(gi))) begin
          r_byte <= i_wr_byte;
        end
      end

      assign o_block[8*gi +: 8] = r_byte;
    end
  endgenerate

  assign o_rd_byte = o_block[{i_rd_idx, 3'b000} +: 8];

endmodule

// File: rtl/cache_refill_ctrl.sv
// Cache miss handler: optional dirty-victim writeback, then a byte-serial line
// fetch, followed by a one-cycle fill strobe and a one-cycle re-lookup slot.
module cache_refill_ctrl
  import cache_refill_ctrl_pkg::*;
#(
  parameter int BLOCK_BYTES = 32,
  parameter int OFF_W       = 5,
  parameter int CNT_W       = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              miss,
  input  logic [31:0]       miss_addr,
  input  logic              victim_dirty,
  input  logic [31:0]       victim_addr,
  input  logic [LINE_W-1:0] victim_block,
  output logic              stall,
  output logic              fill_valid,
  output logic [31:0]       fill_addr,
  output logic [LINE_W-1:0] fill_block,
  output logic              mem_req,
  output logic              mem_we,
  output logic [31:0]       mem_addr,
  output logic [7:0]        mem_wdata,
  input  logic [7:0]        mem_rdata,
  input  logic              mem_ack,
  output logic [CNT_W-1:0]  refill_count
);

  state_t             r_state, w_state_next;
  logic [OFF_W-1:0]   r_cnt, w_cnt_next;
  logic [31:0]        r_line_addr, w_line_next;
  logic [31:0]        r_victim_base, w_victim_next;
  logic               w_capture_victim;
  logic               w_fill_we;
  logic               w_ack;
  logic               w_last;
  logic               w_req_next;
  logic               w_we_next;
  logic [31:0]        w_addr_next;
  logic [7:0]         w_wdata_next;
  logic [7:0]         w_victim_rd_byte;
  logic               r_mem_req, r_mem_we;
  logic [31:0]        r_mem_addr;
  logic [7:0]         r_mem_wdata;
  logic [31:0]        r_fill_addr;
  logic [CNT_W-1:0]   r_refill_count;
  logic [LINE_W-1:0]  w_unused_victim_block;
  logic [7:0]         w_unused_fill_byte;

  // An ack only counts while a request is actually outstanding.
  assign w_ack  = mem_ack & r_mem_req;
  assign w_last = (r_cnt == OFF_W'(BLOCK_BYTES - 1));

  // Next-state, byte counter and address latching.
  always_comb begin
    w_state_next     = r_state;
    w_cnt_next       = r_cnt;
    w_line_next      = r_line_addr;
    w_victim_next    = r_victim_base;
    w_capture_victim = 1'b0;
    w_fill_we        = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (miss) begin
          w_line_next = line_base(miss_addr);
          w_cnt_next  = '0;
          if (victim_dirty) begin
            w_victim_next    = line_base(victim_addr);
            w_capture_victim = 1'b1;
            w_state_next     = ST_WB;
          end else begin
            w_state_next = ST_FETCH;
          end
        end
      end
      ST_WB: begin
        if (w_ack) begin
          w_cnt_next = r_cnt + OFF_W'(1);
          if (w_last) w_state_next = ST_FETCH;
        end
      end
      ST_FETCH: begin
        if (w_ack) begin
          w_fill_we  = 1'b1;
          w_cnt_next = r_cnt + OFF_W'(1);
          if (w_last) w_state_next = ST_FILL;
        end
      end
      ST_FILL: w_state_next = ST_DONE;
      ST_DONE: w_state_next = ST_IDLE;
      default: w_state_next = ST_IDLE;
    endcase
  end

  // Memory-side values for the next cycle; registered so mem_* never glitch.
  always_comb begin
    w_req_next   = (w_state_next == ST_WB) || (w_state_next == ST_FETCH);
    w_we_next    = (w_state_next == ST_WB);
    w_addr_next  = ((w_state_next == ST_WB) ? w_victim_next : w_line_next) + 32'(w_cnt_next);
    // On the miss cycle the victim buffer is not loaded yet, so byte 0 comes straight from the port.
    w_wdata_next = w_capture_victim ? victim_block[7:0] : w_victim_rd_byte;
  end

  // FSM state, byte counter and latched line bases.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state       <= ST_IDLE;
      r_cnt         <= '0;
      r_line_addr   <= '0;
      r_victim_base <= '0;
    end else begin
      r_state       <= w_state_next;
      r_cnt         <= w_cnt_next;
      r_line_addr   <= w_line_next;
      r_victim_base <= w_victim_next;
    end
  end

  // Registered memory interface; address/data only move when a new byte is presented.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_mem_req   <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
    end else begin
      r_mem_req <= w_req_next;
      r_mem_we  <= w_we_next;
      if (w_req_next) r_mem_addr <= w_addr_next;
      if (w_we_next)  r_mem_wdata <= w_wdata_next;
    end
  end

  // Fill address is captured on entry to FILL and then held for the cache.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_fill_addr <= '0;
    end else if (w_state_next == ST_FILL) begin
      r_fill_addr <= r_line_addr;
    end
  end

  // Completed-refill counter, saturating at all-ones.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_refill_count <= '0;
    end else if ((r_state == ST_FILL) && (r_refill_count != {CNT_W{1'b1}})) begin
      r_refill_count <= r_refill_count + CNT_W'(1);
    end
  end

  refill_byte_buffer u_victim_buf (
    .clk         (clk),
    .reset       (reset),
    .i_load      (w_capture_victim),
    .i_load_data (victim_block),
    .i_wr_en     (1'b0),
    .i_wr_idx    ('0),
    .i_wr_byte   (8'h00),
    .i_rd_idx    (w_cnt_next),
    .o_rd_byte   (w_victim_rd_byte),
    .o_block     (w_unused_victim_block)
  );

  refill_byte_buffer u_fill_buf (
    .clk         (clk),
    .reset       (reset),
    .i_load      (1'b0),
    .i_load_data ('0),
    .i_wr_en     (w_fill_we),
    .i_wr_idx    (r_cnt),
    .i_wr_byte   (mem_rdata),
    .i_rd_idx    ('0),
    .o_rd_byte   (w_unused_fill_byte),
    .o_block     (fill_block)
  );

  // Stall covers the miss cycle itself; both strobes are forced low while reset is held.
  assign stall        = reset & ((r_state != ST_IDLE) | miss);
  assign fill_valid   = reset & (r_state == ST_FILL);
  assign fill_addr    = r_fill_addr;
  assign mem_req      = r_mem_req;
  assign mem_we       = r_mem_we;
  assign mem_addr     = r_mem_addr;
  assign mem_wdata    = r_mem_wdata;
  assign refill_count = r_refill_count;

endmodule

// File: doc/cache_refill_ctrl.md
Name: cache_refill_ctrl

Overview:
- Miss handler sitting directly downstream of the cache top: consumes its miss indication and produces the refilled 256-bit block written back into the cache array.
- On a miss it writes back a dirty victim line, then fetches the requested 32-byte line from main memory, one byte per req/ack handshake.
- Holds the pipeline stall for the whole refill and pulses a one-cycle fill strobe when the line is ready.

Parameters:
- BLOCK_BYTES, 32, bytes per cache line (fixed at 32; the 256-bit block width derives from it)
- OFF_W, 5, byte-offset bits, log2(BLOCK_BYTES)
- CNT_W, 16, width of the saturating refill counter

Ports:
- clk  input  1  single clock, rising edge
- reset  input  1  asynchronous, active-low reset (asserted when 0)
- miss  input  1  cache lookup missed this cycle; sampled only in IDLE
- miss_addr  input  32  byte address of the missing access
- victim_dirty  input  1  victim line is dirty, sampled with miss
- victim_addr  input  32  line base address of the victim; low OFF_W bits ignored
- victim_block  input  256  victim line data, byte k = [8k+7:8k]
- stall  output  1  freeze the upstream pipeline
- fill_valid  output  1  one-cycle strobe: fill_block/fill_addr valid
- fill_addr  output  32  line base address being filled, low 5 bits zero
- fill_block  output  256  fetched line, byte k = [8k+7:8k]
- mem_req  output  1  memory request
- mem_we  output  1  1 = write (writeback), 0 = read (fetch)
- mem_addr  output  32  byte address of the current request
- mem_wdata  output  8  writeback byte
- mem_rdata  input  8  fetched byte, valid when mem_ack = 1
- mem_ack  input  1  memory completes the current request this cycle
- refill_count  output  CNT_W  number of completed refills, saturating

Behaviour:
- Reset (reset = 0, asynchronous): state IDLE; counter 0; stall 0; fill_valid 0; mem_req 0; mem_we 0; mem_addr 0; mem_wdata 0; fill_addr 0; fill_block 0; refill_count 0.
- An in-flight refill is abandoned on reset. There is no partial fill strobe, and mem_req drops immediately.
- stall = (state != IDLE) | (state == IDLE & miss), combinational. The miss cycle itself is stalled.
- IDLE: on miss, latch line_addr = {miss_addr[31:5], 5'b0}.
  - If victim_dirty: also latch victim_addr line base and victim_block, go to WB.
  - Otherwise go to FETCH.
  - Byte counter cleared to 0 in both cases.
- WB: mem_req = 1, mem_we = 1, mem_addr = victim base + cnt, mem_wdata = victim byte cnt.
  - On mem_ack: cnt increments.
  - At cnt = 31 with ack: cnt wraps to 0, go to FETCH.
- FETCH: mem_req = 1, mem_we = 0, mem_addr = line_addr + cnt.
  - On mem_ack: fill_block byte cnt <= mem_rdata, cnt increments.
  - At cnt = 31 with ack: go to FILL.
- FILL (one cycle): fill_valid = 1, fill_addr = line_addr, fill_block stable. refill_count increments, saturating at all-ones. Go to DONE.
- DONE (one cycle): stall still 1 so the cache re-looks-up and hits. Go to IDLE.
- Handshake rules:
  - All mem_* outputs are registered. mem_addr/mem_wdata/mem_we are stable while mem_req = 1 and no ack.
  - mem_req stays high across consecutive bytes; an ack in cycle n presents the next byte address in cycle n+1.
  - mem_ack while mem_req = 0 is ignored.
  - mem_ack may arrive the same cycle mem_req first rises.
- Latency: with zero-wait memory (ack every cycle), a clean miss stalls 1 (miss) + 32 + 1 (FILL) + 1 (DONE) = 35 cycles. A dirty miss adds 32 cycles.
- miss while not IDLE is ignored; the latched address governs. miss_addr/victim_* changes during refill have no effect.
- Address arithmetic is 32-bit. The base is line-aligned, so adding cnt never carries out of bit 4.
- fill_block retains its last value after FILL; it is cleared only by reset.

Decomposition:
- Shared package holds:
  - State encoding: IDLE = 0, WB = 1, FETCH = 2, FILL = 3, DONE = 4, in a 3-bit typedef.
  - Constants BLOCK_BYTES = 32, OFF_W = 5, LINE_W = 256.
- One natural sub-module, refill_byte_buffer: 32-byte shift/index register with byte write-enable and byte read mux.
  - Reused twice: once for victim capture, once for fill assembly.

Test Plan:
- Clean miss, miss_addr 0x0000_1234, zero-wait memory returning byte = addr[7:0]:
  - mem_addr runs 0x1220..0x123F, mem_we = 0.
  - fill_valid high exactly once at cycle 34, fill_addr 0x1220, fill_block byte k = 0x20 + k.
  - stall high 35 cycles, refill_count = 1.
- Dirty miss, victim_addr 0x0000_8000, victim_block bytes 0xA0 + k:
  - 32 writes first: mem_we = 1, addresses 0x8000..0x801F, wdata 0xA0..0xBF.
  - Then 32 reads; stall 67 cycles.
- Memory with 2 wait states per byte:
  - mem_addr/mem_wdata hold constant during waits.
  - Total fetch takes 96 cycles; fill contents still correct.
- Spurious mem_ack pulses in IDLE, and a second miss asserted during FETCH:
  - No state change; refill completes for the original line only.
- Reset pulled low at FETCH byte 10:
  - mem_req, stall and fill_valid go to 0 immediately.
  - After release, a new miss starts from cnt = 0; no fill_valid for the aborted line.
- Preload refill_count to 0xFFFE by repeated refills (or force), then run 3 refills:
  - Count saturates at 0xFFFF.
